// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch/jump
// redirect input, and the IF/ID register presented to decode.
interface mips_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  // Fetch stage side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_opcode, id_pc, id_pc_plus4,
    input  id_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_opcode, id_pc, id_pc_plus4,
    output id_ready
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage. Owns the PC, keeps at most one word read in
// flight, and fills the IF/ID register. A one-entry buffer absorbs a word that
// returns while decode is stalled; a redirect kills any wrong-path fetch.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic               clk,
  input logic               rst_n,
  mips_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, STALL} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        kill_reg, kill_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [31:0] buf_data_reg, buf_data_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc_plus4_reg, id_pc_plus4_next;

  logic        handshake;
  logic        id_free;
  logic [31:0] redirect_target;
  logic [31:0] seq_pc;

  assign handshake       = (state_reg == REQ) && bus.imem_req_ready;
  assign id_free         = !id_valid_reg || bus.id_ready;
  assign redirect_target = bus.redirect_pc & ~32'd3;
  // Sequential successor of the word in flight (also the address of the
  // buffered word plus four, since no new request leaves while stalled).
  assign seq_pc          = req_pc_reg + 32'd4;

  assign bus.imem_req_valid = (state_reg == REQ);
  assign bus.imem_req_addr  = pc_reg;
  assign bus.id_valid       = id_valid_reg;
  assign bus.id_instr       = id_instr_reg;
  assign bus.id_opcode      = id_instr_reg[31:26];
  assign bus.id_pc          = id_pc_reg;
  assign bus.id_pc_plus4    = id_pc_plus4_reg;

  // State register and datapath registers; active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      req_pc_reg      <= 32'd0;
      kill_reg        <= 1'b0;
      buf_valid_reg   <= 1'b0;
      buf_data_reg    <= 32'd0;
      id_valid_reg    <= 1'b0;
      id_instr_reg    <= 32'd0;
      id_pc_reg       <= 32'd0;
      id_pc_plus4_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      req_pc_reg      <= req_pc_next;
      kill_reg        <= kill_next;
      buf_valid_reg   <= buf_valid_next;
      buf_data_reg    <= buf_data_next;
      id_valid_reg    <= id_valid_next;
      id_instr_reg    <= id_instr_next;
      id_pc_reg       <= id_pc_next;
      id_pc_plus4_reg <= id_pc_plus4_next;
    end
  end

  // Next-state logic: redirect first, otherwise the normal fetch sequence
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    req_pc_next      = req_pc_reg;
    kill_next        = kill_reg;
    buf_valid_next   = buf_valid_reg;
    buf_data_next    = buf_data_reg;
    id_valid_next    = id_valid_reg;
    id_instr_next    = id_instr_reg;
    id_pc_next       = id_pc_reg;
    id_pc_plus4_next = id_pc_plus4_reg;

    // Decode took the current instruction; it empties unless refilled below.
    if (id_valid_reg && bus.id_ready) begin
      id_valid_next = 1'b0;
    end

    if (bus.redirect_valid) begin
      pc_next        = redirect_target;
      id_valid_next  = 1'b0;
      buf_valid_next = 1'b0;
      case (state_reg)
        BOOT:  state_next = REQ;
        REQ: begin
          if (handshake) begin
            // The request leaving now is wrong-path; drop its response.
            state_next  = WAIT;
            req_pc_next = pc_reg;
            kill_next   = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_next = REQ;
            kill_next  = 1'b0;
          end else begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end
        end
        STALL:   state_next = REQ;
        default: state_next = BOOT;
      endcase
    end else begin
      case (state_reg)
        BOOT: state_next = REQ;
        REQ: begin
          if (handshake) begin
            state_next  = WAIT;
            req_pc_next = pc_reg;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill_reg) begin
              kill_next  = 1'b0;
              state_next = REQ;
            end else if (id_free) begin
              id_valid_next    = 1'b1;
              id_instr_next    = bus.imem_rsp_data;
              id_pc_next       = req_pc_reg;
              id_pc_plus4_next = seq_pc;
              pc_next          = seq_pc;
              state_next       = REQ;
            end else begin
              buf_valid_next = 1'b1;
              buf_data_next  = bus.imem_rsp_data;
              pc_next        = seq_pc;
              state_next     = STALL;
            end
          end
        end
        STALL: begin
          if (bus.id_ready) begin
            id_valid_next    = 1'b1;
            id_instr_next    = buf_data_reg;
            id_pc_next       = req_pc_reg;
            id_pc_plus4_next = seq_pc;
            buf_valid_next   = 1'b0;
            state_next       = REQ;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

endmodule
